// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter: state encoding, field widths
// and the request mux that picks which requester drives the shared port.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_D = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mem_req_t;

    // A fetch is always a full-word read, so it never carries write enables.
    function automatic mem_req_t grant_mux(input logic pick_i,
                                           input logic [ADDR_W-1:0] iaddr,
                                           input mem_req_t dreq);
        mem_req_t r;
        r = dreq;
        if (pick_i) begin
            r.addr  = iaddr;
            r.wen   = 1'b0;
            r.wmask = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data requests onto one memory port, one access in flight.
// Optional ARB_STARVE_GUARD_EN lets fetch win after STARVE_LIMIT consecutive data grants.
//
// state     | meaning
// ST_IDLE   | nothing outstanding, grant allowed
// ST_WAIT_I | fetch outstanding, response routed to iresp
// ST_WAIT_D | data access outstanding, response routed to dresp
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ireq_valid,
    output logic              ireq_ready,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              iresp_valid,
    output logic [ADDR_W-1:0] iresp_addr,
    output logic [DATA_W-1:0] iresp_inst,
    input  logic              dreq_valid,
    output logic              dreq_ready,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic              dreq_wen,
    input  logic [DATA_W-1:0] dreq_wdata,
    input  logic [MASK_W-1:0] dreq_wmask,
    output logic              dresp_valid,
    output logic [DATA_W-1:0] dresp_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [ADDR_W-1:0] mem_resp_addr,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    arb_state_e state_q, state_d;
    logic       grant_ok, pick_i, hs, starve_hit;
    mem_req_t   dreq_s, win_s;

    // Outputs are gated by rst_n so nothing handshakes while reset is held.
    assign grant_ok = (state_q == ST_IDLE) || mem_resp_valid;
    assign pick_i   = ireq_valid && (!dreq_valid || starve_hit);
    assign mem_valid  = rst_n && grant_ok && (ireq_valid || dreq_valid);
    assign hs         = mem_valid && mem_ready;
    assign ireq_ready = hs && pick_i;
    assign dreq_ready = hs && !pick_i;

    assign dreq_s    = '{addr: dreq_addr, wen: dreq_wen, wdata: dreq_wdata, wmask: dreq_wmask};
    assign win_s     = grant_mux(pick_i, ireq_addr, dreq_s);
    assign mem_addr  = win_s.addr;
    assign mem_wen   = win_s.wen;
    assign mem_wdata = win_s.wdata;
    assign mem_wmask = win_s.wmask;

    assign iresp_valid = rst_n && (state_q == ST_WAIT_I) && mem_resp_valid;
    assign iresp_addr  = mem_resp_addr;
    assign iresp_inst  = mem_resp_rdata;
    assign dresp_valid = rst_n && (state_q == ST_WAIT_D) && mem_resp_valid;
    assign dresp_rdata = mem_resp_rdata;

    always_comb begin
        state_d = state_q;
        if (hs) begin
            state_d = pick_i ? ST_WAIT_I : ST_WAIT_D;
        end else if ((state_q != ST_IDLE) && mem_resp_valid) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    logic [CNT_W-1:0] starve_q, starve_d;

    assign starve_hit = (starve_q >= CNT_W'(STARVE_LIMIT));

    // Only data grants made while fetch is actually waiting count toward starvation.
    always_comb begin
        starve_d = starve_q;
        if (ireq_ready) begin
            starve_d = '0;
        end else if (dreq_ready) begin
            if (!ireq_valid) begin
                starve_d = '0;
            end else if (!starve_hit) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict data priority; the limit only matters with the guard compiled in.
    assign starve_hit = (STARVE_LIMIT < 0);
`endif

endmodule
